sparc_exu_alu_pipe: RTL and testbench
=====================================

# sparc_exu_alu_pipe

Parametrised, pipelined successor to the single-cycle SPARC EXU ALU/shifter datapath. Performs add/sub with carry, inverted-operand logic ops, moves, SETHI and 32/64-bit shifts. Produces SPARC icc/xcc condition codes. Carries the result through a configurable-depth register pipeline with valid/ready backpressure, flush and a tag passthrough. Sits between the bypass/operand-read logic and the writeback/bypass-return path.

## Interface
- WIDTH, 64: datapath width; legal values 32 or 64.
- STAGES, 2: pipeline register stages, 1..4; equals latency.
- TAG_W, 5: width of the opaque tag (destination register id).
- rclk in 1: clock, rising edge.
- arst in 1: reset, asynchronous, active-high.
- in_valid in 1: operation offered.
- in_ready out 1: operation accepted when in_valid && in_ready.
- in_op in 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV, 6 SLL, 7 SRL, 8 SRA, 9 SETHI, 10-15 illegal.
- in_op32 in 1: 32-bit shift mode (WIDTH=64 only; ignored when WIDTH=32).
- in_invert in 1: logic ops use ~rs2 (ANDN/ORN/XNOR); ignored for other ops.
- in_cin in 1: carry-in (ADDC/SUBC).
- in_rs1, in_rs2 in WIDTH: operands.
- in_tag in TAG_W: passthrough tag.
- flush in 1: synchronous kill of all in-flight ops.
- out_valid out 1: result available.
- out_ready in 1: consumer accepts when out_valid && out_ready.
- out_data out WIDTH: result.
- out_icc, out_xcc out 4: {N,Z,V,C} for bits [31:0] and [WIDTH-1:0].
- out_tag out TAG_W: tag of the result.
- out_illegal out 1: result came from an illegal opcode.
- occ out $clog2(STAGES+1): number of valid stages.

## Operation
- Compute is combinational on the accepted inputs and is captured into stage 0. Stages 1..STAGES-1 only move data. Output ports are driven by the last stage.
- ADD: rs1+rs2+cin. SUB: rs1-rs2-cin.
  - C = carry-out (ADD) or borrow (SUB), taken at bit 31 for icc and at bit WIDTH-1 for xcc.
  - V = two's-complement overflow at the same bit.
- AND/OR/XOR: rs1 op (in_invert ? ~rs2 : rs2). MOV: rs2.
- SETHI: {rs2[21:0], 10'b0}, zero-extended to WIDTH.
- Shifts:
  - op32=0: count = rs2[$clog2(WIDTH)-1:0].
  - op32=1: count = rs2[4:0]; the operation uses rs1[31:0].
    - SLL result zero-extended from 32 bits.
    - SRL result zero-extended.
    - SRA result sign-extended from bit 31.
- N and Z come from the result for every op. For logic, MOV, SETHI and shifts, V=C=0.
- Illegal op: out_data=0, icc=xcc=0, out_illegal=1. It still flows through the pipeline normally.
- When WIDTH=32, xcc equals icc.
- Stage advance:
  - Stage k loads when it is empty or stage k+1 advances. The last stage advances when out_ready is high.
  - in_ready = stage 0 can load, and flush is low.
- flush: every valid bit is cleared at the next edge and occ becomes 0. in_ready=0 during the flush cycle, so no op is accepted that cycle.
- occ is updated every cycle. It counts +1 on accept and -1 on output handshake; both in the same cycle leave it unchanged. It saturates at neither end, by construction.

## Timing
- Latency: an op accepted at edge N appears on out_valid after edge N+STAGES-1, i.e. STAGES cycles from offer to result with no stall.
- Throughput is 1 op/cycle while out_ready is held high. With STAGES full and out_ready=0, in_ready drops to 0 in the same cycle.
- out_* are stable while out_valid && !out_ready.
- Reset (asserted at any time, including mid-operation): all valid bits, data, tags, cc, out_illegal and occ go to 0 immediately. in_ready goes to 1 once arst deasserts.
- Ops leave in the order they were accepted; no reordering.

## Test plan
- ADD, WIDTH=64: rs1=FFFF_FFFF_FFFF_FFFF, rs2=1, cin=0 -> data=0; xcc=0101, icc=0101 after STAGES cycles.
- SUB: rs1=0000_0000_8000_0000, rs2=1 -> data=0000_0000_7FFF_FFFF; icc=0010 (V); xcc=0000.
- SRA op32: rs1=0000_0000_8000_0000, rs2=4 -> FFFF_FFFF_F800_0000, icc N=1. SETHI rs2=3F_FFFF -> FFFF_FC00 with zero upper bits.
- Backpressure, STAGES=2: out_ready=0, offer tags 1,2,3.
  - Tags 1 and 2 are accepted, occ=2, in_ready=0.
  - Raise out_ready: tags 1,2,3 emerge in order on consecutive cycles.
- Flush with occ=2 and in_valid=1: next cycle occ=0 and out_valid=0; the offered op is not accepted and is re-taken the following cycle.
- Assert arst with 2 ops in flight: outputs clear at once and occ=0; after release, a new ADD 2+3 -> 5 after STAGES cycles. Also op 12 -> out_illegal=1, data=0.

Source files
------------

// File: rtl/sparc_exu_alu_pipe.sv
// Pipelined SPARC EXU ALU/shifter: add/sub with carry, logic ops, MOV, SETHI and shifts,
// with icc/xcc codes, carried through a valid/ready register pipeline with flush and tag.
module sparc_exu_alu_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic             rclk,
  input  logic             arst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_op32,
  input  logic             in_invert,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_icc,
  output logic [3:0]       out_xcc,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [OCC_W-1:0] occ
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_MOV   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SETHI = 4'd9;
  localparam int SH_W = $clog2(WIDTH);
  localparam int HB   = (WIDTH > 32) ? 32 : 0;

  logic [WIDTH-1:0] rs2_l, alu_res;
  logic [WIDTH:0]   sum_w;
  logic [63:0]      ext;
  logic [31:0]      sh32;
  logic             c_lo, v_lo, c_hi, v_hi, alu_ill, sgn_lo, sgn_hi, use32;
  logic [3:0]       alu_icc, alu_xcc;

  assign use32 = (WIDTH == 64) && in_op32;

  always_comb begin
    rs2_l   = in_invert ? ~in_rs2 : in_rs2;
    sum_w   = '0;
    ext     = '0;
    sh32    = '0;
    alu_res = '0;
    c_lo    = 1'b0;
    v_lo    = 1'b0;
    c_hi    = 1'b0;
    v_hi    = 1'b0;
    sgn_lo  = 1'b0;
    sgn_hi  = 1'b0;
    alu_ill = 1'b0;
    case (in_op)
      OP_ADD, OP_SUB: begin
        if (in_op == OP_SUB) begin
          sum_w  = {1'b0, in_rs1} - {1'b0, in_rs2} - (WIDTH+1)'(in_cin);
          sgn_lo = in_rs1[31] ^ in_rs2[31];
          sgn_hi = in_rs1[WIDTH-1] ^ in_rs2[WIDTH-1];
        end else begin
          sum_w  = {1'b0, in_rs1} + {1'b0, in_rs2} + (WIDTH+1)'(in_cin);
          sgn_lo = in_rs1[31] ~^ in_rs2[31];
          sgn_hi = in_rs1[WIDTH-1] ~^ in_rs2[WIDTH-1];
        end
        alu_res = sum_w[WIDTH-1:0];
        c_hi    = sum_w[WIDTH];
        // Carry/borrow out of bit 31 recovered from bit 32: sum32 = a32 ^ b32 ^ carry31.
        c_lo    = (WIDTH > 32) ? (sum_w[32] ^ in_rs1[HB] ^ in_rs2[HB]) : sum_w[WIDTH];
        v_lo    = sgn_lo && (alu_res[31] != in_rs1[31]);
        v_hi    = sgn_hi && (alu_res[WIDTH-1] != in_rs1[WIDTH-1]);
      end
      OP_AND: alu_res = in_rs1 & rs2_l;
      OP_OR:  alu_res = in_rs1 | rs2_l;
      OP_XOR: alu_res = in_rs1 ^ rs2_l;
      OP_MOV: alu_res = in_rs2;
      OP_SLL: begin
        if (use32) begin
          sh32    = in_rs1[31:0] << in_rs2[4:0];
          ext     = {32'b0, sh32};
          alu_res = ext[WIDTH-1:0];
        end else begin
          alu_res = in_rs1 << in_rs2[SH_W-1:0];
        end
      end
      OP_SRL: begin
        if (use32) begin
          sh32    = in_rs1[31:0] >> in_rs2[4:0];
          ext     = {32'b0, sh32};
          alu_res = ext[WIDTH-1:0];
        end else begin
          alu_res = in_rs1 >> in_rs2[SH_W-1:0];
        end
      end
      OP_SRA: begin
        if (use32) begin
          sh32    = $signed(in_rs1[31:0]) >>> in_rs2[4:0];
          ext     = {{32{sh32[31]}}, sh32};
          alu_res = ext[WIDTH-1:0];
        end else begin
          alu_res = $signed(in_rs1) >>> in_rs2[SH_W-1:0];
        end
      end
      OP_SETHI: begin
        ext     = {32'b0, in_rs2[21:0], 10'b0};
        alu_res = ext[WIDTH-1:0];
      end
      default: alu_ill = 1'b1;
    endcase
    alu_icc = alu_ill ? 4'b0 : {alu_res[31], alu_res[31:0] == 32'b0, v_lo, c_lo};
    alu_xcc = alu_ill ? 4'b0 : {alu_res[WIDTH-1], alu_res == '0, v_hi, c_hi};
  end

  logic [STAGES-1:0] valid_reg, load, src_valid, ill_reg, src_ill;
  logic [WIDTH-1:0]  data_reg [STAGES];
  logic [WIDTH-1:0]  src_data [STAGES];
  logic [3:0]        icc_reg  [STAGES];
  logic [3:0]        src_icc  [STAGES];
  logic [3:0]        xcc_reg  [STAGES];
  logic [3:0]        src_xcc  [STAGES];
  logic [TAG_W-1:0]  tag_reg  [STAGES];
  logic [TAG_W-1:0]  src_tag  [STAGES];
  logic [OCC_W-1:0]  occ_reg;
  logic              accept, out_fire;

  assign in_ready = load[0] && !flush;
  assign accept   = in_valid && in_ready;
  assign out_fire = valid_reg[STAGES-1] && out_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // A stage can take new data if the output drains or any stage at or after it holds a bubble.
      assign load[gi] = out_ready || !(&valid_reg[STAGES-1:gi]);
      if (gi == 0) begin : g_head
        assign src_valid[gi] = accept;
        assign src_data[gi]  = alu_res;
        assign src_icc[gi]   = alu_icc;
        assign src_xcc[gi]   = alu_xcc;
        assign src_tag[gi]   = in_tag;
        assign src_ill[gi]   = alu_ill;
      end else begin : g_body
        assign src_valid[gi] = valid_reg[gi-1];
        assign src_data[gi]  = data_reg[gi-1];
        assign src_icc[gi]   = icc_reg[gi-1];
        assign src_xcc[gi]   = xcc_reg[gi-1];
        assign src_tag[gi]   = tag_reg[gi-1];
        assign src_ill[gi]   = ill_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      valid_reg <= '0;
      ill_reg   <= '0;
      occ_reg   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_reg[k] <= '0;
        icc_reg[k]  <= '0;
        xcc_reg[k]  <= '0;
        tag_reg[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          data_reg[k] <= src_data[k];
          icc_reg[k]  <= src_icc[k];
          xcc_reg[k]  <= src_xcc[k];
          tag_reg[k]  <= src_tag[k];
          ill_reg[k]  <= src_ill[k];
        end
      end
      valid_reg <= flush ? '0 : ((load & src_valid) | (~load & valid_reg));
      occ_reg   <= flush ? '0 : occ_reg + OCC_W'(accept) - OCC_W'(out_fire);
    end
  end

  assign out_valid   = valid_reg[STAGES-1];
  assign out_data    = data_reg[STAGES-1];
  assign out_icc     = icc_reg[STAGES-1];
  assign out_xcc     = xcc_reg[STAGES-1];
  assign out_tag     = tag_reg[STAGES-1];
  assign out_illegal = ill_reg[STAGES-1];
  assign occ         = occ_reg;

endmodule

// File: tb/tb_sparc_exu_alu_pipe.sv
// Scoreboard bench for sparc_exu_alu_pipe: directed plan vectors, backpressure, flush,
// async reset, then randomized traffic checked against an arithmetic reference model.
module tb_sparc_exu_alu_pipe;
  localparam int WIDTH  = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int OCC_W  = $clog2(STAGES + 1);

  logic             clk, arst, in_valid, in_ready, in_op32, in_invert, in_cin, flush;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_rs1, in_rs2, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             out_valid, out_ready, out_illegal;
  logic [3:0]       out_icc, out_xcc;
  logic [OCC_W-1:0] occ;

  sparc_exu_alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .rclk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_op32(in_op32), .in_invert(in_invert), .in_cin(in_cin), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_icc(out_icc), .out_xcc(out_xcc),
    .out_tag(out_tag), .out_illegal(out_illegal), .occ(occ)
  );

  typedef struct {
    logic [3:0]  op;
    logic        op32, inv, cin;
    logic [63:0] rs1, rs2;
    logic [4:0]  tag;
  } req_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  icc, xcc;
    logic        ill;
    logic [4:0]  tag;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [63:0] specials [6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {V,C} from the true mathematical result of the add/subtract at w bits.
  function automatic logic [1:0] arith_vc(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input bit sub);
    logic signed [127:0] sa, sb, st, lim, sc;
    logic [127:0] ua, ub, uc;
    logic v, c;
    if (w == 32) begin
      ua = {96'b0, a[31:0]};
      ub = {96'b0, b[31:0]};
      sa = {{96{a[31]}}, a[31:0]};
      sb = {{96{b[31]}}, b[31:0]};
    end else begin
      ua = {64'b0, a};
      ub = {64'b0, b};
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
    end
    sc  = {127'b0, cin};
    uc  = {127'b0, cin};
    lim = 128'sd1 <<< (w - 1);
    if (sub) begin
      st = sa - sb - sc;
      c  = ua < (ub + uc);
    end else begin
      st = sa + sb + sc;
      c  = (ua + ub + uc) >= (128'd1 << w);
    end
    v = (st >= lim) || (st < -lim);
    return {v, c};
  endfunction

  function automatic exp_t model(input req_t r);
    exp_t e;
    logic [63:0] b;
    logic [1:0] vc_lo, vc_hi;
    longint signed s64;
    int signed s32;
    e.tag = r.tag; e.acc_cyc = -1; e.ill = 1'b0; vc_lo = 2'b0; vc_hi = 2'b0;
    b = r.inv ? ~r.rs2 : r.rs2;
    case (r.op)
      4'd0: begin
        e.data = r.rs1 + r.rs2 + 64'(r.cin);
        vc_lo = arith_vc(32, r.rs1, r.rs2, r.cin, 1'b0);
        vc_hi = arith_vc(64, r.rs1, r.rs2, r.cin, 1'b0);
      end
      4'd1: begin
        e.data = r.rs1 - r.rs2 - 64'(r.cin);
        vc_lo = arith_vc(32, r.rs1, r.rs2, r.cin, 1'b1);
        vc_hi = arith_vc(64, r.rs1, r.rs2, r.cin, 1'b1);
      end
      4'd2: e.data = r.rs1 & b;
      4'd3: e.data = r.rs1 | b;
      4'd4: e.data = r.rs1 ^ b;
      4'd5: e.data = r.rs2;
      4'd6: e.data = r.op32 ? {32'b0, r.rs1[31:0] << r.rs2[4:0]} : r.rs1 << r.rs2[5:0];
      4'd7: e.data = r.op32 ? {32'b0, r.rs1[31:0] >> r.rs2[4:0]} : r.rs1 >> r.rs2[5:0];
      4'd8: begin
        if (r.op32) begin
          s32 = r.rs1[31:0];
          s32 = s32 >>> r.rs2[4:0];
          e.data = longint'(s32);
        end else begin
          s64 = r.rs1;
          e.data = s64 >>> r.rs2[5:0];
        end
      end
      4'd9: e.data = {32'b0, r.rs2[21:0], 10'b0};
      default: begin e.data = 64'b0; e.ill = 1'b1; end
    endcase
    if (e.ill) begin
      e.icc = 4'b0; e.xcc = 4'b0;
    end else begin
      e.icc = {e.data[31], e.data[31:0] == 32'b0, vc_lo};
      e.xcc = {e.data[63], e.data == 64'b0, vc_hi};
    end
    return e;
  endfunction

  function automatic req_t mkreq(input logic [3:0] op, input logic op32, input logic inv,
                                 input logic cin, input logic [63:0] rs1, input logic [63:0] rs2,
                                 input logic [4:0] tag);
    req_t r;
    r.op = op; r.op32 = op32; r.inv = inv; r.cin = cin; r.rs1 = rs1; r.rs2 = rs2; r.tag = tag;
    return r;
  endfunction

  function automatic exp_t mkexp(input logic [63:0] data, input logic [3:0] icc,
                                 input logic [3:0] xcc, input logic ill, input logic [4:0] tag);
    exp_t e;
    e.data = data; e.icc = icc; e.xcc = xcc; e.ill = ill; e.tag = tag; e.acc_cyc = -1;
    return e;
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 3))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 70));
      2: return {32'b0, $urandom};
      default: return specials[$urandom_range(0, 5)];
    endcase
  endfunction

  task automatic set_in(input req_t r);
    in_op = r.op; in_op32 = r.op32; in_invert = r.inv; in_cin = r.cin;
    in_rs1 = r.rs1; in_rs2 = r.rs2; in_tag = r.tag;
  endtask

  // Offer one op until accepted (bounded); pushes the expected result on accept.
  task automatic offer(input req_t r, input exp_t e, input bit lat);
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      set_in(r);
      in_valid = 1'b1;
      #2;
      if (in_ready) begin
        e.acc_cyc = lat ? cyc : -1;
        q.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL offer_timeout: tag %0d got not-accepted expected accepted", r.tag);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Monitor: occupancy vs scoreboard depth, then pop/compare on each output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!arst) chk("occ", 64'(occ), 64'(q.size()));
      #2;
      if (!arst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: got tag %0d expected none", out_tag);
        end else begin
          e = q.pop_front();
          $display("tx tag=%0d data=%h icc=%b xcc=%b ill=%b", out_tag, out_data, out_icc,
                   out_xcc, out_illegal);
          chk("data", out_data, e.data);
          chk("icc", 64'(out_icc), 64'(e.icc));
          chk("xcc", 64'(out_xcc), 64'(e.xcc));
          chk("illegal", 64'(out_illegal), 64'(e.ill));
          chk("tag", 64'(out_tag), 64'(e.tag));
          if (e.acc_cyc >= 0) chk("latency", 64'(cyc - e.acc_cyc), 64'(STAGES));
        end
      end
    end
  end

  initial begin
    req_t r;
    exp_t e;
    specials[0] = 64'hFFFF_FFFF_FFFF_FFFF; specials[1] = 64'h0000_0000_8000_0000;
    specials[2] = 64'h7FFF_FFFF_FFFF_FFFF; specials[3] = 64'h0000_0000_7FFF_FFFF;
    specials[4] = 64'h8000_0000_0000_0000; specials[5] = 64'h0000_0000_FFFF_FFFF;
    arst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    set_in(mkreq(4'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0));

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    #2 chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Plan vectors, back to back with out_ready high
    offer(mkreq(4'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd1),
          mkexp(64'd0, 4'b0101, 4'b0101, 1'b0, 5'd1), 1'b1);
    offer(mkreq(4'd1, 1'b0, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'd1, 5'd2),
          mkexp(64'h0000_0000_7FFF_FFFF, 4'b0010, 4'b0000, 1'b0, 5'd2), 1'b1);
    offer(mkreq(4'd8, 1'b1, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'd4, 5'd3),
          mkexp(64'hFFFF_FFFF_F800_0000, 4'b1000, 4'b1000, 1'b0, 5'd3), 1'b1);
    offer(mkreq(4'd9, 1'b0, 1'b0, 1'b0, 64'd0, 64'h3F_FFFF, 5'd4),
          mkexp(64'h0000_0000_FFFF_FC00, 4'b1000, 4'b0000, 1'b0, 5'd4), 1'b1);
    idle(4);

    // Backpressure
    out_ready = 1'b0;
    r = mkreq(4'd0, 1'b0, 1'b0, 1'b0, 64'd10, 64'd1, 5'd1);
    offer(r, model(r), 1'b0);
    r = mkreq(4'd0, 1'b0, 1'b0, 1'b0, 64'd20, 64'd2, 5'd2);
    offer(r, model(r), 1'b0);
    r = mkreq(4'd0, 1'b0, 1'b0, 1'b0, 64'd30, 64'd3, 5'd3);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_in(r); in_valid = 1'b1;
      #2;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_occ", 64'(occ), 64'd2);
      chk("bp_hold_tag", 64'(out_tag), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #2;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    if (in_ready) q.push_back(model(r));
    #2;
    chk("bp_order_valid", 64'(out_valid), 64'd1);
    chk("bp_order_tag", 64'(out_tag), 64'd1);
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #4;
      chk("bp_order_valid", 64'(out_valid), 64'd1);
      chk("bp_order_tag", 64'(out_tag), 64'(k));
    end
    idle(3);

    // Flush with two ops in flight and a new op offered
    out_ready = 1'b0;
    r = mkreq(4'd3, 1'b0, 1'b1, 1'b0, 64'h0F0F, 64'h00FF, 5'd4);
    offer(r, model(r), 1'b0);
    r = mkreq(4'd4, 1'b0, 1'b1, 1'b0, 64'h1234, 64'h5678, 5'd5);
    offer(r, model(r), 1'b0);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    r = mkreq(4'd2, 1'b0, 1'b1, 1'b0, 64'hFF00, 64'h0F0F, 5'd6);
    set_in(r); in_valid = 1'b1;
    #2 chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    q.delete();
    @(negedge clk);
    flush = 1'b0;
    #2;
    chk("flush_occ", 64'(occ), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_retake", 64'(in_ready), 64'd1);
    if (in_ready) begin
      e = model(r);
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    idle(4);

    // Asynchronous reset with two ops in flight
    out_ready = 1'b0;
    r = mkreq(4'd0, 1'b0, 1'b0, 1'b1, 64'd7, 64'd8, 5'd7);
    offer(r, model(r), 1'b0);
    r = mkreq(4'd6, 1'b0, 1'b0, 1'b0, 64'd1, 64'd63, 5'd8);
    offer(r, model(r), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #4 arst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_occ", 64'(occ), 64'd0);
    chk("arst_data", out_data, 64'd0);
    chk("arst_tag", 64'(out_tag), 64'd0);
    chk("arst_cc", 64'({out_icc, out_xcc}), 64'd0);
    q.delete();
    @(negedge clk);
    arst = 1'b0; out_ready = 1'b1;
    #2 chk("arst_in_ready", 64'(in_ready), 64'd1);
    offer(mkreq(4'd0, 1'b0, 1'b0, 1'b0, 64'd2, 64'd3, 5'd9),
          mkexp(64'd5, 4'b0000, 4'b0000, 1'b0, 5'd9), 1'b1);
    offer(mkreq(4'd12, 1'b0, 1'b0, 1'b0, 64'd55, 64'd66, 5'd10),
          mkexp(64'd0, 4'b0000, 4'b0000, 1'b1, 5'd10), 1'b1);
    idle(4);

    // Randomized traffic with random backpressure and occasional flush
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      r = mkreq(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), rand_operand(), rand_operand(), 5'($urandom_range(0, 31)));
      set_in(r);
      #2;
      if (in_valid && in_ready) q.push_back(model(r));
      if (flush) begin
        @(posedge clk);
        q.delete();
      end
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(STAGES + 3);
    #2;
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_occ", 64'(occ), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
